light_rx: RTL and testbench
===========================

// Module: light_rx
// PURPOSE
// - Standalone receive end of the LED light link: decodes the serial on/off signal driven by a
//   transceiver's led output into PACKET_SIZE-bit words.
// - Sits between the photodetector input (signal) and the host; raises irq_rx per good frame.
// - Frame on the wire: idle 0, start bit 1, PACKET_SIZE data bits LSB first, [parity], stop bit 0.
// - Each bit lasts BIT_TICKS clocks.
// PARAMETERS
// - PACKET_SIZE  `PACKET_SIZE (8)  data bits per frame
// - BIT_TICKS    16                clocks per bit; even, >= 4
// - SYNC_STAGES  2                 flip-flops in the signal synchronizer; >= 2
// PORTS
// - clock      in   1            single system clock, rising edge
// - reset      in   1            asynchronous, active-high; clears all state
// - rx_enable  in   1            1 = receiver armed; 0 = ignore line / abort frame
// - signal     in   1            raw asynchronous light input (peer led)
// - rx_ack     in   1            1-cycle pulse from host; clears irq_rx and overrun
// - data_out   out  PACKET_SIZE  last good word; updated only on a good frame
// - irq_rx     out  1            sticky level: good frame available
// - busy       out  1            1 while state != IDLE
// - frame_err  out  1            sticky: stop bit sampled 1; cleared by rx_ack
// - overrun    out  1            sticky: good frame completed while irq_rx already 1
// - parity_err out  1            sticky parity mismatch (see CONFIGURATION); cleared by rx_ack
// BEHAVIOUR
// - Reset values: data_out=0, irq_rx=0, busy=0, frame_err=0, overrun=0, parity_err=0, state IDLE.
// - Synchronizer: signal passes SYNC_STAGES flops -> s. Edge E = first cycle with s=1 and previous s=0.
// - Bit counter: $clog2(PACKET_SIZE+2) bits. Tick counter: $clog2(BIT_TICKS) bits.
// - FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
//   - IDLE: go to START on E when rx_enable=1.
//   - START: at E+BIT_TICKS/2 sample s. s=0 -> glitch -> IDLE, no flags. s=1 -> DATA.
//   - DATA: bit i (i=0..PACKET_SIZE-1) sampled at E+BIT_TICKS/2+(i+1)*BIT_TICKS, shifted in LSB first.
//   - PARITY (macro only): sampled one BIT_TICKS after the last data bit.
//   - STOP: sampled one BIT_TICKS after the last data or parity bit.
//     - s=0 -> load data_out. irq_rx=1 on the next cycle. IDLE.
//     - s=1 -> frame_err=1, data_out kept, irq_rx unchanged, WAIT_IDLE.
//   - WAIT_IDLE: return to IDLE after s=0 holds for BIT_TICKS consecutive cycles.
// - Latency without parity: irq_rx rises at E+BIT_TICKS/2+(PACKET_SIZE+1)*BIT_TICKS+1.
//   - E itself is SYNC_STAGES cycles after the raw rising edge.
// - Overrun: good frame completes while irq_rx=1 -> overrun=1 and data_out overwritten.
// - rx_ack in the same cycle as a good completion: irq_rx stays 1; overrun not set; error flags cleared.
// - rx_enable=0 in any non-IDLE state: abort to IDLE next cycle, no flag changes, data_out kept.
// - reset mid-frame: immediate return to reset values. A frame in flight is lost.
//   Reception resumes only on a fresh E.
// - A continuous line 1 never produces a second E until s returns to 0.
// CONFIGURATION
// - LIGHT_RX_PARITY_EN defined:
//   - One even-parity bit follows the data bits (XOR of data and parity = 0).
//   - Mismatch at a good stop bit: parity_err=1, data_out not loaded, irq_rx not set.
//   - Latency grows by BIT_TICKS.
// - LIGHT_RX_PARITY_EN undefined:
//   - No parity slot and no PARITY state.
//   - parity_err is tied to 0; the port stays present.
// TESTING (BIT_TICKS=4, SYNC_STAGES=2, PACKET_SIZE=8, macro off unless noted)
// - Good frame 0x50 ('P') -> data_out=0x50; irq_rx rises at E+39, busy=0 afterwards; rx_ack -> irq_rx=0.
// - 1-cycle glitch high on signal in IDLE -> return to IDLE at E+2; no irq_rx, no flags, data_out unchanged.
// - Frame 0x45 with stop bit held 1 -> frame_err=1, irq_rx=0, data_out keeps previous 0x50.
//   - Line back to 0 for 4 cycles, then frame 0x54 -> received correctly.
// - Frames 0x45 then 0x54 with no rx_ack -> overrun=1, data_out=0x54, irq_rx=1.
//   - rx_ack -> irq_rx=0 and overrun=0.
// - reset pulse at E+20 of frame 0x52 -> all outputs 0 immediately; next frame 0x41 -> data_out=0x41.
// - Macro on: frame 0x41 with parity 0 -> data_out=0x41, irq_rx at E+43.
//   - Frame 0x41 with parity 1 -> parity_err=1, no irq_rx.

Source files
------------

// File: rtl/light_rx.sv
// -----------------------------------------------------------------------------
// light_rx -- receive end of the LED light link.
//
// Decodes the serial on/off light signal (peer led output) into PACKET_SIZE-bit
// words. Frame on the wire: idle 0, start 1, PACKET_SIZE data bits LSB first,
// optional even-parity bit, stop 0. Each bit lasts BIT_TICKS clocks.
//
// Build option: define LIGHT_RX_PARITY_EN to add the even-parity bit after the
// data bits. Undefined: no parity slot, parity_err tied to 0.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   rx_enable  1 = receiver armed; 0 = ignore line / abort frame in flight
//   signal     raw asynchronous light input
//   rx_ack     1-cycle host pulse; clears irq_rx, overrun and the error flags
//   data_out   last good word (only updated by a good frame)
//   irq_rx     sticky: good frame available
//   busy       receiver not idle
//   frame_err  sticky: stop bit sampled 1
//   overrun    sticky: good frame completed while irq_rx already set
//   parity_err sticky: parity mismatch on an otherwise good frame
// -----------------------------------------------------------------------------
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module light_rx #(
  parameter int PACKET_SIZE = `PACKET_SIZE,
  parameter int BIT_TICKS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_enable,
  input  logic                   signal,
  input  logic                   rx_ack,
  output logic [PACKET_SIZE-1:0] data_out,
  output logic                   irq_rx,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam int BCW = $clog2(PACKET_SIZE + 2);
  localparam int TCW = $clog2(BIT_TICKS);
  localparam logic [TCW-1:0] HALF_M1  = TCW'(BIT_TICKS / 2 - 1);
  localparam logic [TCW-1:0] FULL_M1  = TCW'(BIT_TICKS - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PACKET_SIZE - 1);

`ifdef LIGHT_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [TCW-1:0]         tick_q, tick_d;
  logic [BCW-1:0]         bit_q, bit_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d;
  logic [PACKET_SIZE-1:0] data_q, data_d;
  logic                   irq_q, irq_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
`ifdef LIGHT_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  logic s, rise, tick_last;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_prev_q;
  assign tick_last = (tick_q == FULL_M1);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], signal};
    s_prev_d = s;
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    irq_d    = irq_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
`ifdef LIGHT_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif

    // Host ack clears first; events completing this cycle override below.
    if (rx_ack) begin
      irq_d  = 1'b0;
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
`ifdef LIGHT_RX_PARITY_EN
      perr_d = 1'b0;
`endif
    end

    if (state_q != IDLE && !rx_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_enable && rise) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        // Mid-start-bit check rejects glitches shorter than half a bit.
        START: begin
          if (tick_q == HALF_M1) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = s ? DATA : IDLE;
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_d  = '0;
            shreg_d = {s, shreg_q[PACKET_SIZE-1:1]};
            bit_d   = bit_q + BCW'(1);
            if (bit_q == LAST_BIT) begin
`ifdef LIGHT_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
`ifdef LIGHT_RX_PARITY_EN
        PARITY: begin
          if (tick_last) begin
            tick_d  = '0;
            par_d   = s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_last) begin
            tick_d = '0;
            if (s) begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end else begin
              state_d = IDLE;
`ifdef LIGHT_RX_PARITY_EN
              if (^{shreg_q, par_q}) begin
                perr_d = 1'b1;
              end else begin
`else
              begin
`endif
                data_d = shreg_q;
                irq_d  = 1'b1;
                // irq_d already reflects an ack this cycle, which masks overrun.
                if (irq_q && !rx_ack) ovr_d = 1'b1;
              end
            end
          end else begin
            tick_d = tick_q + TCW'(1);
          end
        end
        // Any 1 restarts the count: need BIT_TICKS consecutive zeros.
        WAIT_IDLE: begin
          if (s)              tick_d  = '0;
          else if (tick_last) state_d = IDLE;
          else                tick_d  = tick_q + TCW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizer and edge history reset high: a line already high when reset
  // releases is not a start edge; a real 0->1 transition is required.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_q   <= '1;
      s_prev_q <= 1'b1;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      irq_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef LIGHT_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      irq_q    <= irq_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef LIGHT_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign irq_rx    = irq_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef LIGHT_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_light_rx.sv
// -----------------------------------------------------------------------------
// tb_light_rx -- self-checking bench for light_rx (BIT_TICKS=4, SYNC_STAGES=2,
// PACKET_SIZE=8). Frames are built as bit vectors and replayed one bit per
// BIT_TICKS clocks; a flag-level model predicts the host-visible outputs and
// the cycle at which irq_rx rises relative to the raw start edge.
// -----------------------------------------------------------------------------
module tb_light_rx;
  localparam int PS = 8;
  localparam int BT = 4;
  localparam int SS = 2;
`ifdef LIGHT_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB  = PS + 2 + PB;
  // raw start rise -> irq_rx high: synchronizer, half bit, remaining bits, register
  localparam int LAT = SS + BT / 2 + (PS + 1 + PB) * BT + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_enable = 1'b0;
  logic          signal = 1'b0;
  logic          rx_ack = 1'b0;
  logic [PS-1:0] data_out;
  logic          irq_rx, busy, frame_err, overrun, parity_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   irq_rise = -1;
  logic irq_prev = 1'b0;
  int   t_start = 0;

  logic [7:0] m_data;
  logic       m_irq, m_ovr, m_ferr, m_perr;

  light_rx #(.PACKET_SIZE(PS), .BIT_TICKS(BT), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable), .signal(signal),
    .rx_ack(rx_ack), .data_out(data_out), .irq_rx(irq_rx), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #1;
    if (irq_rx && !irq_prev) irq_rise = cyc;
    irq_prev = irq_rx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},      32'(data_out),   32'(m_data));
    chk({tag, ".irq"},       32'(irq_rx),     32'(m_irq));
    chk({tag, ".overrun"},   32'(overrun),    32'(m_ovr));
    chk({tag, ".frame_err"}, 32'(frame_err),  32'(m_ferr));
    chk({tag, ".parity"},    32'(parity_err), 32'(m_perr));
  endtask

  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic stop_b,
                                           input logic par_b);
    logic [11:0] f;
    f      = '0;
    f[0]   = 1'b1;
    f[8:1] = d;
`ifdef LIGHT_RX_PARITY_EN
    f[9]   = par_b;
    f[10]  = stop_b;
`else
    f[9]   = stop_b;
`endif
    f[11]  = par_b & ~par_b;
    return f;
  endfunction

  // Replays the first ncyc clocks of frame f, starting at the current negedge.
  task automatic send_bits(input logic [11:0] f, input int ncyc);
    t_start = cyc;
    for (int k = 0; k < ncyc; k++) begin
      signal = f[k / BT];
      @(negedge clock);
    end
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    m_irq = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                       input logic ack_stop, input int idle, input string tag);
    logic was_irq, good;
    good    = !stop_b && (PB == 0 || ((^d) == par_b));
    was_irq = m_irq;
    send_bits(mk_frame(d, stop_b, par_b), NB * BT);
    signal = 1'b0;
    // The task returns on the cycle the stop bit is sampled, so an ack here
    // lands in the same cycle as the completion.
    if (ack_stop) begin
      rx_ack = 1'b1;
      @(negedge clock);
      rx_ack = 1'b0;
      m_irq = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
    end
    if (stop_b) m_ferr = 1;
    else if (!good) m_perr = 1;
    else begin
      if (m_irq) m_ovr = 1;
      m_irq  = 1;
      m_data = d;
    end
    repeat (idle) @(negedge clock);
    check_all(tag);
    if (good && !was_irq) chk({tag, ".rise"}, 32'(irq_rise), 32'(t_start + LAT));
    if (idle >= 8) chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       st, pb;
    m_data = 0; m_irq = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;

    repeat (3) @(negedge clock);
    check_all("reset");
    chk("reset.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rx_enable = 1'b1;
    repeat (4) @(negedge clock);

    // good frame 'P', then ack
    frame(8'h50, 1'b0, ^8'h50, 1'b0, 12, "p50");
    ack();
    check_all("ack1");

    // single-cycle glitch: start check at mid-bit throws it away
    signal = 1'b1;
    @(negedge clock);
    signal = 1'b0;
    repeat (2) @(negedge clock);
    chk("glitch.busy1", 32'(busy), 32'd1);
    repeat (3) @(negedge clock);
    chk("glitch.busy0", 32'(busy), 32'd0);
    check_all("glitch");

    // stop held high, line back low for exactly BIT_TICKS clocks, next frame
    frame(8'h45, 1'b1, ^8'h45, 1'b0, 4, "ferr");
    frame(8'h54, 1'b0, ^8'h54, 1'b0, 12, "after_ferr");
    ack();

    // overrun
    frame(8'h45, 1'b0, ^8'h45, 1'b0, 12, "ovr1");
    frame(8'h54, 1'b0, ^8'h54, 1'b0, 12, "ovr2");
    ack();
    check_all("ovr_ack");

    // ack coincident with a good completion while irq already set
    frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 12, "ferr2");
    frame(8'hA5, 1'b0, ^8'hA5, 1'b0, 12, "pre_co");
    frame(8'h5A, 1'b0, ^8'h5A, 1'b1, 12, "ack_co");
    ack();

    // rx_enable drop mid-frame aborts with no flag changes
    send_bits(mk_frame(8'h99, 1'b0, ^8'h99), 16);
    chk("abort.busy1", 32'(busy), 32'd1);
    rx_enable = 1'b0;
    signal = 1'b0;
    @(negedge clock);
    chk("abort.busy0", 32'(busy), 32'd0);
    repeat (8) @(negedge clock);
    rx_enable = 1'b1;
    repeat (4) @(negedge clock);
    check_all("abort");

    // continuous high: one frame error, then parked until the line drops
    signal = 1'b1;
    repeat (80) @(negedge clock);
    m_ferr = 1;
    chk("const1.busy", 32'(busy), 32'd1);
    check_all("const1");
    signal = 1'b0;
    repeat (10) @(negedge clock);
    chk("const1.busy0", 32'(busy), 32'd0);
    ack();

    // reset at E+20 of frame 0x52
    frame(8'h33, 1'b0, ^8'h33, 1'b0, 12, "pre_rst");
    send_bits(mk_frame(8'h52, 1'b0, ^8'h52), SS + 20);
    chk("rst.busy1", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    m_data = 0; m_irq = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
    check_all("rst");
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    signal = 1'b0;
    repeat (8) @(negedge clock);
    chk("rst.idle", 32'(busy), 32'd0);
    check_all("rst_idle");
    frame(8'h41, 1'b0, ^8'h41, 1'b0, 12, "after_rst");
    ack();

`ifdef LIGHT_RX_PARITY_EN
    frame(8'h41, 1'b0, 1'b0, 1'b0, 12, "par_ok");
    ack();
    frame(8'h41, 1'b0, 1'b1, 1'b0, 12, "par_bad");
    ack();
`endif

    // randomized frames: bad stops, bad parity, occasional ack
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 3) == 0);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) ack();
      frame(d, st, pb, 1'b0, 12, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
